// File: rtl/pen_smp_scheduler_if.sv
// Avalon-MM slave register bus for the pen sample scheduler.
// Ports: address[1:0], chipselect, write_n, read_n, writedata[31:0] (master -> slave),
//        readdata[31:0] (slave -> master, combinational, zero wait states).
interface pen_smp_scheduler_if;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic        read_n;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (
      output address, chipselect, write_n, read_n, writedata,
      input  readdata
   );

   modport slave (
      input  address, chipselect, write_n, read_n, writedata,
      output readdata
   );
endinterface

// File: rtl/pen_smp_scheduler.sv
// Periodic pen sampler scheduler: issues sample_req every max(speed,1) clocks and
// buffers acknowledged samples in a FIFO_DEPTH-entry FIFO read through an Avalon-MM slave.
// Latency: sample_req registered; pushed data visible in STATUS/DATA the cycle after ack.
// Backpressure: a late ack causes missed ticks (counted in MISSED); full FIFO drops samples.
// Ports: clk, reset_n (async active-low), avs (register bus), speed[15:0],
//        sample_req / sample_ack / sample_data[15:0] (sampler handshake),
//        irq (only when the PEN_SMP_IRQ_EN macro is defined).
// Register map: 0 CTRL {irq_mask, enable; bit2 flush W1}, 1 STATUS, 2 DATA (pop), 3 MISSED.
module pen_smp_scheduler #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic               clk,
   input  logic               reset_n,
   pen_smp_scheduler_if.slave avs,
   input  logic [15:0]        speed,
   output logic               sample_req,
   input  logic               sample_ack,
   input  logic [15:0]        sample_data
`ifdef PEN_SMP_IRQ_EN
   ,
   output logic               irq
`endif
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_COUNT = 2'd1,
      ST_REQ   = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [15:0]   cnt_q, cnt_d;
   logic [15:0]   period_q, period_d;
   logic [15:0]   period_new;
   logic          req_q;
   logic          tick;
   logic          late_evt;

   logic          enable_q;
   logic          irq_mask_q;
   logic          ovf_q;
   logic          late_q;
   logic [15:0]   missed_q;

   logic [15:0]   mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [LW-1:0] level_q;
   logic [4:0]    level5;
   logic          fifo_empty, fifo_full;
   logic          push, push_ok, pop, flush, ovf_evt;

   logic          wr_en, wr_ctrl, wr_stat;
   logic          unused_wdata;

   // ---------------------------------------------------------------- bus decode
   assign wr_en   = avs.chipselect & ~avs.write_n;
   assign wr_ctrl = wr_en & (avs.address == 2'd0);
   assign wr_stat = wr_en & (avs.address == 2'd1);
   assign flush   = wr_ctrl & avs.writedata[2];
   // Reading an empty FIFO has no side effect.
   assign pop     = avs.chipselect & ~avs.read_n & (avs.address == 2'd2) & ~fifo_empty;

   assign unused_wdata = ^{avs.writedata[31:9], avs.writedata[6:3], avs.writedata[1]};

   // ---------------------------------------------------------------- tick FSM
   assign period_new = (speed == 16'd0) ? 16'd1 : speed;
   // The counter keeps running in REQ so ticks that land there can be counted as late.
   assign tick       = (state_q != ST_IDLE) && (cnt_q == period_q - 16'd1);

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      period_d = period_q;
      late_evt = 1'b0;
      case (state_q)
         ST_IDLE: begin
            cnt_d    = 16'd0;
            period_d = period_new;
            if (enable_q) state_d = ST_COUNT;
         end
         ST_COUNT: begin
            if (!enable_q) begin
               state_d = ST_IDLE;
               cnt_d   = 16'd0;
            end else if (tick) begin
               state_d  = ST_REQ;
               cnt_d    = 16'd0;
               period_d = period_new;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         ST_REQ: begin
            if (tick) begin
               late_evt = 1'b1;
               cnt_d    = 16'd0;
               period_d = period_new;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
            // Disabling never aborts an outstanding request; only the ack leaves REQ.
            if (sample_ack) begin
               if (enable_q) begin
                  state_d = ST_COUNT;
               end else begin
                  state_d = ST_IDLE;
                  cnt_d   = 16'd0;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = 16'd0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= 16'd0;
         period_q <= 16'd1;
         req_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         period_q <= period_d;
         req_q    <= (state_d == ST_REQ);
      end
   end

   assign sample_req = req_q;

   // ---------------------------------------------------------------- sample FIFO
   assign fifo_empty = (level_q == '0);
   assign fifo_full  = (level_q == DEPTH_L);
   assign push       = (state_q == ST_REQ) & sample_ack;
   // A same-cycle pop frees the slot, so a push into a full FIFO still lands.
   assign push_ok    = push & (~fifo_full | pop);
   assign ovf_evt    = push & fifo_full & ~pop & ~flush;
   assign level5     = 5'(level_q);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else if (flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({push_ok, pop})
            2'b10:   level_q <= level_q + LW'(1);
            2'b01:   level_q <= level_q - LW'(1);
            default: level_q <= level_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok && !flush) mem_q[wr_ptr_q] <= sample_data;
   end

   // ---------------------------------------------------------------- registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         enable_q <= 1'b0;
         ovf_q    <= 1'b0;
         late_q   <= 1'b0;
         missed_q <= 16'd0;
      end else begin
         if (wr_ctrl) enable_q <= avs.writedata[0];
         // A new event in the same cycle as a write-1-to-clear wins.
         if (ovf_evt)                          ovf_q <= 1'b1;
         else if (wr_stat && avs.writedata[7]) ovf_q <= 1'b0;
         if (late_evt)                          late_q <= 1'b1;
         else if (wr_stat && avs.writedata[8]) late_q <= 1'b0;
         if (late_evt && missed_q != 16'hFFFF) missed_q <= missed_q + 16'd1;
      end
   end

`ifdef PEN_SMP_IRQ_EN
   logic irq_q;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         irq_mask_q <= 1'b0;
         irq_q      <= 1'b0;
      end else begin
         if (wr_ctrl) irq_mask_q <= avs.writedata[1];
         irq_q <= irq_mask_q & (~fifo_empty | ovf_q);
      end
   end
   assign irq = irq_q;
`else
   assign irq_mask_q = 1'b0;
`endif

   // ---------------------------------------------------------------- read mux
   always_comb begin
      avs.readdata = 32'd0;
      case (avs.address)
         2'd0: avs.readdata[1:0] = {irq_mask_q, enable_q};
         2'd1: avs.readdata[8:0] = {late_q, ovf_q, fifo_full, fifo_empty, level5};
         2'd2: if (!fifo_empty) avs.readdata[15:0] = mem_q[rd_ptr_q];
         default: avs.readdata[15:0] = missed_q;
      endcase
   end

endmodule
